// File: rtl/scan_decoder.sv
// Registered N-line active-low decoder with G1/G2A/G2B enables
// and an autonomous line scan with programmable dwell and guard gap.
module scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8,
  parameter int GUARD   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  g1_en_i,
  input  logic                  g2a_en_n_i,
  input  logic                  g2b_en_n_i,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [DWELL_W-1:0]    dwell_i,
  output logic [2**SEL_W-1:0]   yn_o,
  output logic [SEL_W-1:0]      idx_o,
  output logic                  valid_o,
  output logic                  wrap_o
);

  localparam int N  = 2**SEL_W;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N-1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN_ON,
    SCAN_GUARD
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sidx_q, sidx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]      gcnt_q, gcnt_d;
  logic [N-1:0]       yn_q, yn_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;

  logic               en;
  logic               adv;
  logic [SEL_W-1:0]   nxt;

  function automatic logic [N-1:0] dec(input logic [SEL_W-1:0] s);
    logic [N-1:0] one;
    one = {{(N-1){1'b0}}, 1'b1};
    return ~(one << s);
  endfunction

  assign en  = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;
  assign nxt = sidx_q + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    sidx_d  = sidx_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    yn_d    = '1;
    idx_d   = idx_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    adv     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      sidx_d  = '0;
      cnt_d   = '0;
      gcnt_d  = '0;
    end else if (!mode_i) begin
      state_d = DIRECT;
      sidx_d  = '0;
      cnt_d   = '0;
      gcnt_d  = '0;
      yn_d    = dec(sel_i);
      idx_d   = sel_i;
      valid_d = 1'b1;
    end else begin
      unique case (state_q)
        SCAN_ON: begin
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - DWELL_W'(1);
            yn_d    = dec(sidx_q);
            idx_d   = sidx_q;
            valid_d = 1'b1;
          end else if (GUARD == 0) begin
            adv = 1'b1;
          end else begin
            state_d = SCAN_GUARD;
            gcnt_d  = GW'(GUARD - 1);
          end
        end
        SCAN_GUARD: begin
          if (gcnt_q != '0) gcnt_d = gcnt_q - GW'(1);
          else              adv    = 1'b1;
        end
        default: begin
          // fresh scan entry always starts at line 0, no wrap
          state_d = SCAN_ON;
          sidx_d  = '0;
          cnt_d   = dwell_i;
          gcnt_d  = '0;
          yn_d    = dec('0);
          idx_d   = '0;
          valid_d = 1'b1;
        end
      endcase
      if (adv) begin
        state_d = SCAN_ON;
        sidx_d  = nxt;
        cnt_d   = dwell_i;
        gcnt_d  = '0;
        yn_d    = dec(nxt);
        idx_d   = nxt;
        valid_d = 1'b1;
        wrap_d  = (sidx_q == LAST);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      sidx_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      yn_q    <= '1;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sidx_q  <= sidx_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      yn_q    <= yn_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign yn_o    = yn_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;

endmodule
